// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared datapath constants and fetch FSM encoding.
`default_nettype none

package if_stage_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT  = 16'h0000;
  localparam logic [DATA_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_add.sv
// Add: 16-bit ripple-carry adder built from a chain of full adders.
`default_nettype none

module Add
  import if_stage_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic [DATA_W-1:0] S,
  output logic              Cout
);

  logic [DATA_W:0] carry;

  assign carry[0] = Cin;

  generate
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      assign S[i]       = A[i] ^ B[i] ^ carry[i];
      assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  endgenerate

  assign Cout = carry[DATA_W];

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC register, IF/ID pipeline register,
// BOOT/RUN start-up FSM and accepted-instruction counter.
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_pc_plus1,
  output logic [DATA_W-1:0] if_id_instr,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] fetch_count
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [DATA_W-1:0] pc_plus1;
  logic              add_cout_unused;

  // Carry-out is dropped so the PC wraps from FFFF to 0000.
  Add u_pc_inc (
    .A    (pc),
    .B    (16'h0001),
    .Cin  (1'b0),
    .S    (pc_plus1),
    .Cout (add_cout_unused)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
    end else if (state == BOOT) begin
      // Stall and redirect are ignored until the first fetch cycle.
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc             <= branch_target;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_plus1;
      if_id_instr    <= imem_data;
      if_id_pc_plus1 <= pc_plus1;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
`default_nettype none

module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [15:0] NOP = 16'hBEEF;
  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] if_id_pc_plus1;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ KEY;

  if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pc             (pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 16'h0000); end
    checks++;
    if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", if_id_instr, NOP); end
    checks++;
    if (if_id_valid !== 1'b0 || if_id_pc_plus1 !== 16'h0000) begin
      errors++; $display("FAIL reset_ifid got v=%b p1=%h want v=0 p1=0000", if_id_valid, if_id_pc_plus1);
    end
    checks++;
    if (fetch_count !== 16'h0000 || dut.state !== BOOT) begin
      errors++; $display("FAIL reset_cnt_state got cnt=%h st=%b want cnt=0000 st=0", fetch_count, dut.state);
    end
  endtask

  task automatic test_free_run();
    logic [15:0] exp_instr;
    rst = 1'b0;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || pc !== 16'h0000 || fetch_count !== 16'h0000 || dut.state !== RUN) begin
      errors++; $display("FAIL boot_bubble got v=%b pc=%h cnt=%h st=%b want v=0 pc=0000 cnt=0000 st=1",
                         if_id_valid, pc, fetch_count, dut.state);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_instr = 16'(i - 1) ^ KEY;
      checks++;
      if (if_id_instr !== exp_instr || if_id_pc_plus1 !== 16'(i) || if_id_valid !== 1'b1 ||
          pc !== 16'(i) || fetch_count !== 16'(i)) begin
        errors++; $display("FAIL free_run_%0d got instr=%h p1=%h v=%b pc=%h cnt=%h want instr=%h p1=%h v=1 pc=%h cnt=%h",
                           i, if_id_instr, if_id_pc_plus1, if_id_valid, pc, fetch_count,
                           exp_instr, 16'(i), 16'(i), 16'(i));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 16'h0005 || if_id_instr !== 16'hA5A1 || if_id_pc_plus1 !== 16'h0005 ||
          if_id_valid !== 1'b1 || fetch_count !== 16'h0005) begin
        errors++; $display("FAIL stall_hold_%0d got pc=%h instr=%h p1=%h v=%b cnt=%h want pc=0005 instr=a5a1 p1=0005 v=1 cnt=0005",
                           i, pc, if_id_instr, if_id_pc_plus1, if_id_valid, fetch_count);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0006 || if_id_instr !== 16'hA5A0 || if_id_pc_plus1 !== 16'h0006 || fetch_count !== 16'h0006) begin
      errors++; $display("FAIL stall_resume got pc=%h instr=%h p1=%h cnt=%h want pc=0006 instr=a5a0 p1=0006 cnt=0006",
                         pc, if_id_instr, if_id_pc_plus1, fetch_count);
    end
  endtask

  task automatic test_branch();
    tick();
    tick();
    tick();
    checks++;
    if (pc !== 16'h0009 || fetch_count !== 16'h0009) begin
      errors++; $display("FAIL pre_branch got pc=%h cnt=%h want pc=0009 cnt=0009", pc, fetch_count);
    end
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (pc !== 16'h0040 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
        if_id_pc_plus1 !== 16'h0000 || fetch_count !== 16'h0009) begin
      errors++; $display("FAIL branch_flush got pc=%h v=%b instr=%h p1=%h cnt=%h want pc=0040 v=0 instr=%h p1=0000 cnt=0009",
                         pc, if_id_valid, if_id_instr, if_id_pc_plus1, fetch_count, NOP);
    end
    tick();
    checks++;
    if (if_id_instr !== 16'hA5E5 || if_id_pc_plus1 !== 16'h0041 || if_id_valid !== 1'b1 ||
        pc !== 16'h0041 || fetch_count !== 16'h000A) begin
      errors++; $display("FAIL branch_target_fetch got instr=%h p1=%h v=%b pc=%h cnt=%h want instr=a5e5 p1=0041 v=1 pc=0041 cnt=000a",
                         if_id_instr, if_id_pc_plus1, if_id_valid, pc, fetch_count);
    end
  endtask

  task automatic test_branch_stall();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    tick();
    stall        = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (pc !== 16'h0100 || if_id_valid !== 1'b0 || if_id_instr !== NOP || fetch_count !== 16'h000A) begin
      errors++; $display("FAIL branch_over_stall got pc=%h v=%b instr=%h cnt=%h want pc=0100 v=0 instr=%h cnt=000a",
                         pc, if_id_valid, if_id_instr, fetch_count, NOP);
    end
    tick();
    checks++;
    if (if_id_instr !== 16'hA4A5 || fetch_count !== 16'h000B || pc !== 16'h0101) begin
      errors++; $display("FAIL after_branch_stall got instr=%h cnt=%h pc=%h want instr=a4a5 cnt=000b pc=0101",
                         if_id_instr, fetch_count, pc);
    end
  endtask

  task automatic test_pc_wrap();
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_branch got pc=%h want ffff", pc); end
    tick();
    checks++;
    if (pc !== 16'h0000 || if_id_pc_plus1 !== 16'h0000 || if_id_instr !== 16'h5A5A ||
        if_id_valid !== 1'b1 || fetch_count !== 16'h000C) begin
      errors++; $display("FAIL pc_wrap got pc=%h p1=%h instr=%h v=%b cnt=%h want pc=0000 p1=0000 instr=5a5a v=1 cnt=000c",
                         pc, if_id_pc_plus1, if_id_instr, if_id_valid, fetch_count);
    end
  endtask

  task automatic test_reset_mid_branch();
    tick();
    rst           = 1'b1;
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 16'h0055;
    tick();
    checks++;
    if (pc !== 16'h0000 || fetch_count !== 16'h0000 || dut.state !== BOOT || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_branch got pc=%h cnt=%h st=%b v=%b want pc=0000 cnt=0000 st=0 v=0",
                         pc, fetch_count, dut.state, if_id_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0000 || if_id_valid !== 1'b0 || if_id_instr !== NOP || dut.state !== RUN) begin
      errors++; $display("FAIL boot_ignores_ctrl got pc=%h v=%b instr=%h st=%b want pc=0000 v=0 instr=%h st=1",
                         pc, if_id_valid, if_id_instr, dut.state, NOP);
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    tick();
    checks++;
    if (if_id_instr !== 16'hA5A5 || if_id_pc_plus1 !== 16'h0001 || pc !== 16'h0001 || fetch_count !== 16'h0001) begin
      errors++; $display("FAIL first_fetch_after_reset got instr=%h p1=%h pc=%h cnt=%h want instr=a5a5 p1=0001 pc=0001 cnt=0001",
                         if_id_instr, if_id_pc_plus1, pc, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_pc_wrap();
    test_reset_mid_branch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0000, the instruction word driven into IF/ID as a bubble.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port stall, input, 1, hazard-unit hold request.
REQ-006 SHALL have port branch_taken, input, 1, redirect request from the ID/EX stage.
REQ-007 SHALL have port branch_target, input, 16, redirect destination PC.
REQ-008 SHALL have port imem_addr, output, 16, combinational instruction-memory address, equal to pc.
REQ-009 SHALL have port imem_data, input, 16, combinational instruction-memory read data for imem_addr.
REQ-010 SHALL have port pc, output, 16, the current fetch PC register.
REQ-011 SHALL have port if_id_pc_plus1, output, 16, registered PC+1 of the instruction in IF/ID.
REQ-012 SHALL have port if_id_instr, output, 16, registered instruction word.
REQ-013 SHALL have port if_id_valid, output, 1, high when IF/ID holds a real instruction, not a bubble.
REQ-014 SHALL have port fetch_count, output, 16, count of instructions accepted into IF/ID.

Function
REQ-015 SHALL compute pc_plus1 = pc + 1 combinationally over 16 bits; the carry-out SHALL be discarded, so 16'hFFFF wraps to 16'h0000.
REQ-016 SHALL apply priority rst > branch_taken > stall > normal advance on each rising edge.
REQ-017 SHALL, on normal advance, set pc <= pc_plus1, if_id_instr <= imem_data, if_id_pc_plus1 <= pc_plus1, if_id_valid <= 1, and fetch_count <= fetch_count + 1.
REQ-018 SHALL, on stall without branch_taken, hold pc, all IF/ID outputs and fetch_count unchanged.
REQ-019 SHALL, on branch_taken, set pc <= branch_target, if_id_instr <= NOP_INSTR, if_id_pc_plus1 <= 0 and if_id_valid <= 0 (flush), and leave fetch_count unchanged, regardless of stall.
REQ-020 SHALL run a 2-state FSM. BOOT is entered on reset. BOOT transitions to RUN after one cycle, and in BOOT the IF/ID register is loaded with a bubble and pc is held at RESET_PC. RUN remains RUN until reset.
REQ-021 SHALL ignore stall and branch_taken while in BOOT.
REQ-022 SHALL wrap fetch_count from 16'hFFFF to 16'h0000 without any flag.
REQ-023 SHALL have a latency of one cycle from imem_data sampled at pc to its appearance on if_id_instr.

Reset
REQ-024 SHALL, while rst is high at a rising edge, set pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus1=0, if_id_valid=0, fetch_count=0 and FSM=BOOT.
REQ-025 SHALL let rst asserted mid-operation (including during stall or branch_taken) override everything on that edge.
REQ-026 SHALL first fetch from RESET_PC on the second rising edge after rst deasserts.

Structure
REQ-027 SHALL place RESET_PC default, NOP_INSTR default, the 16-bit data width and the FSM state encoding (BOOT=1'b0, RUN=1'b1) in the shared datapath package.
REQ-028 SHALL implement the PC incrementer as one sub-module instance of the existing 16-bit ripple-carry adder Add, with B=16'h0001, Cin=0 and Cout left unconnected.
REQ-029 SHALL keep all other logic (PC register, IF/ID register, FSM, counter) in if_stage.

Verification
REQ-030 SHALL cover reset then free run: rst for 2 cycles, imem_data=addr^16'hA5A5, no stall. Required: cycle 1 bubble (if_id_valid=0), then if_id_instr=16'hA5A5 with if_id_pc_plus1=1, then 16'hA5A4 with 2; fetch_count increments each cycle.
REQ-031 SHALL cover stall: stall high for 3 cycles at pc=5. Required: pc stays 5, IF/ID and fetch_count frozen; advance resumes on the cycle after stall drops.
REQ-032 SHALL cover branch: branch_taken=1, branch_target=16'h0040 at pc=9. Required: next cycle pc=16'h0040, if_id_valid=0, if_id_instr=NOP_INSTR; following cycle if_id_instr=imem[16'h0040].
REQ-033 SHALL cover branch with stall together: stall=1 and branch_taken=1 with target 16'h0100. Required: pc=16'h0100 and IF/ID flushed (branch wins).
REQ-034 SHALL cover PC wrap: branch to 16'hFFFF, then advance. Required: if_id_pc_plus1=16'h0000 and pc=16'h0000.
REQ-035 SHALL cover reset mid-branch: rst=1 and branch_taken=1 on the same edge. Required: pc=RESET_PC, fetch_count=0, FSM=BOOT.
